// File: rtl/encoder_ctrl_pkg.sv
// Shared types and step arithmetic for the encoder parameter controller.
package encoder_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} SwState;

    localparam int MAX_PARAMS = 16;
    typedef logic [$clog2(MAX_PARAMS)-1:0] sel_t;

    // Apply one signed step to old_v and clamp the result to [0, max_v].
    function automatic int unsigned clamp_step(input int unsigned old_v,
                                               input int unsigned step,
                                               input logic        up,
                                               input int unsigned max_v);
        if (up)
            return (old_v + step > max_v) ? max_v : old_v + step;
        else
            return (step > old_v) ? 0 : old_v - step;
    endfunction

endpackage

// File: rtl/param_update_scheduler.sv
// Dirty-mask bookkeeping and lowest-index-first change notification over valid/ready.
module param_update_scheduler
    import encoder_ctrl_pkg::*;
#(
    parameter int  NUM_PARAMS  = 4,
    parameter int  PARAM_WIDTH = 8,
    localparam int SEL_W       = $clog2(NUM_PARAMS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PARAMS-1:0]                  chg_mask,
    input  logic [NUM_PARAMS-1:0][PARAM_WIDTH-1:0] params,
    input  logic                                   upd_ready,
    output logic                                   upd_valid,
    output logic [SEL_W-1:0]                       upd_index,
    output logic [PARAM_WIDTH-1:0]                 upd_value
);

    logic [NUM_PARAMS-1:0] dirty;
    logic [NUM_PARAMS-1:0] clr_mask;
    logic [SEL_W-1:0]      pick;
    logic                  load;

    always_comb begin
        pick = '0;
        for (int i = NUM_PARAMS-1; i >= 0; i--)
            if (dirty[i]) pick = SEL_W'(i);
    end

    assign load = (~upd_valid | upd_ready) & (|dirty);

    always_comb begin
        clr_mask = '0;
        if (load) clr_mask[pick] = 1'b1;
    end

    // A change landing in the load cycle re-sets the bit, so it is notified again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dirty     <= '1;
            upd_valid <= 1'b0;
            upd_index <= '0;
            upd_value <= '0;
        end else begin
            dirty <= (dirty & ~clr_mask) | chg_mask;
            if (load) begin
                upd_valid <= 1'b1;
                upd_index <= pick;
                upd_value <= params[pick];
            end else if (upd_ready) begin
                upd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/encoder_param_ctrl.sv
// Turns encoder detents and switch presses into a bank of saturating parameters.
module encoder_param_ctrl
    import encoder_ctrl_pkg::*;
#(
    parameter int  NUM_PARAMS    = 4,
    parameter int  PARAM_WIDTH   = 8,
    parameter int  DEFAULT_VALUE = 2**(PARAM_WIDTH-1),
    parameter int  FAST_WINDOW   = 2_400_000,
    parameter int  FAST_STEP     = 4,
    parameter int  LONG_PRESS    = 24_000_000,
    localparam int SEL_W         = $clog2(NUM_PARAMS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enc_state_change_stb,
    input  logic                              enc_clockwise,
    input  logic                              enc_click,
    input  logic                              enc_switch,
    output logic [SEL_W-1:0]                  param_sel,
    output logic [NUM_PARAMS*PARAM_WIDTH-1:0] param_flat,
    output logic                              upd_valid,
    input  logic                              upd_ready,
    output logic [SEL_W-1:0]                  upd_index,
    output logic [PARAM_WIDTH-1:0]            upd_value
);

    localparam int IW    = $clog2(FAST_WINDOW+1);
    localparam int HW    = $clog2(LONG_PRESS+1);
    localparam int MAX_V = (2**PARAM_WIDTH) - 1;

    logic                                   click_q, seen_detent;
    logic [IW-1:0]                          ivl_cnt;
    logic [HW-1:0]                          hold_cnt;
    SwState                                 sw_state, sw_next;
    logic [NUM_PARAMS-1:0][PARAM_WIDTH-1:0] params;
    logic [SEL_W-1:0]                       sel;
    logic                                   detent, fast, short_press, restore;
    logic [PARAM_WIDTH-1:0]                 cur_val, new_val;
    logic [NUM_PARAMS-1:0]                  chg_mask;

    assign detent = enc_state_change_stb & enc_click & ~click_q;
    // The counter starts at zero, so the very first detent must be forced slow.
    assign fast   = seen_detent & (ivl_cnt < IW'(FAST_WINDOW));

    always_comb begin
        sw_next     = sw_state;
        short_press = 1'b0;
        restore     = 1'b0;
        case (sw_state)
            IDLE:    if (!enc_switch) sw_next = PRESSED;
            PRESSED: begin
                if (hold_cnt == HW'(LONG_PRESS)) begin
                    restore = 1'b1;
                    sw_next = HELD;
                end else if (enc_switch) begin
                    short_press = 1'b1;
                    sw_next     = IDLE;
                end
            end
            HELD:    if (enc_switch) sw_next = IDLE;
            default: sw_next = IDLE;
        endcase
    end

    // Restore and detent both target the pre-update selection; restore wins.
    always_comb begin
        cur_val = params[sel];
        new_val = cur_val;
        if (restore)
            new_val = PARAM_WIDTH'(DEFAULT_VALUE);
        else if (detent)
            new_val = PARAM_WIDTH'(clamp_step(32'(cur_val), fast ? 32'(FAST_STEP) : 32'd1,
                                              enc_clockwise, MAX_V));
        chg_mask      = '0;
        chg_mask[sel] = (new_val != cur_val);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            click_q     <= 1'b0;
            seen_detent <= 1'b0;
            ivl_cnt     <= '0;
            hold_cnt    <= '0;
            sw_state    <= IDLE;
            sel         <= '0;
            params      <= {NUM_PARAMS{PARAM_WIDTH'(DEFAULT_VALUE)}};
        end else begin
            click_q  <= enc_click;
            sw_state <= sw_next;
            if (detent) begin
                ivl_cnt     <= '0;
                seen_detent <= 1'b1;
            end else if (ivl_cnt < IW'(FAST_WINDOW)) begin
                ivl_cnt <= ivl_cnt + IW'(1);
            end
            if (sw_state == IDLE)
                hold_cnt <= '0;
            else if (sw_state == PRESSED && hold_cnt != HW'(LONG_PRESS))
                hold_cnt <= hold_cnt + HW'(1);
            if (short_press)
                sel <= (sel == SEL_W'(NUM_PARAMS-1)) ? '0 : sel + SEL_W'(1);
            params[sel] <= new_val;
        end
    end

    assign param_sel  = sel;
    assign param_flat = params;

    param_update_scheduler #(
        .NUM_PARAMS (NUM_PARAMS),
        .PARAM_WIDTH(PARAM_WIDTH)
    ) u_sched (
        .clk      (clk),
        .reset    (reset),
        .chg_mask (chg_mask),
        .params   (params),
        .upd_ready(upd_ready),
        .upd_valid(upd_valid),
        .upd_index(upd_index),
        .upd_value(upd_value)
    );

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Self-checking bench: detent vector table, directed press sequences, randomized run vs model.
module tb_encoder_param_ctrl;
    localparam int NP = 4, PW = 8, FW = 20, FS = 4, LP = 40, SW = 2;

    logic clk = 1'b0, reset = 1'b0;
    logic stb = 1'b0, cw = 1'b0, click = 1'b0, sw = 1'b1, upd_ready = 1'b0;
    logic [SW-1:0]    param_sel, upd_index;
    logic [NP*PW-1:0] param_flat;
    logic             upd_valid;
    logic [PW-1:0]    upd_value;

    always #5 clk = ~clk;

    encoder_param_ctrl #(
        .NUM_PARAMS(NP), .PARAM_WIDTH(PW), .DEFAULT_VALUE(128),
        .FAST_WINDOW(FW), .FAST_STEP(FS), .LONG_PRESS(LP)
    ) dut (
        .clk(clk), .reset(reset),
        .enc_state_change_stb(stb), .enc_clockwise(cw), .enc_click(click), .enc_switch(sw),
        .param_sel(param_sel), .param_flat(param_flat),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_index(upd_index), .upd_value(upd_value)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; int val; } note_t;
    note_t notes[$];
    int    last_val[NP];

    always @(negedge clk)
        if (reset && upd_valid && upd_ready) begin
            notes.push_back('{int'(upd_index), int'(upd_value)});
            last_val[upd_index] = int'(upd_value);
        end

    typedef struct { bit up; int extra; int exp_val; bit exp_note; } vec_t;
    vec_t tbl[$];

    int n_pass = 0, n_tot = 0, q_rd = 0;
    int m_param[NP];
    int m_sel = 0, m_last_cyc = 0;
    bit m_prev = 1'b0, rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) upd_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic int model_step(input int v, input bit up, input bit fast);
        int r;
        r = up ? v + (fast ? FS : 1) : v - (fast ? FS : 1);
        if (r < 0) r = 0;
        if (r > (1 << PW) - 1) r = (1 << PW) - 1;
        return r;
    endfunction

    function automatic logic [NP*PW-1:0] model_flat();
        logic [NP*PW-1:0] f;
        for (int i = 0; i < NP; i++) f[i*PW +: PW] = PW'(m_param[i]);
        return f;
    endfunction

    task automatic do_reset();
        reset = 1'b0; stb = 1'b0; click = 1'b0; sw = 1'b1;
        #1;
        chk("reset_drops_valid", upd_valid, 0);
        for (int i = 0; i < NP; i++) m_param[i] = 128;
        m_sel = 0; m_prev = 1'b0;
        tick(); tick();
        chk("reset_sel", param_sel, 0);
        chk("reset_params", param_flat, model_flat());
        chk("reset_valid", upd_valid, 0);
        chk("reset_index", upd_index, 0);
        chk("reset_value", upd_value, 0);
        reset = 1'b1;
    endtask

    task automatic drain();
        upd_ready = 1'b1;
        repeat (NP + 3) tick();
        q_rd = notes.size();
    endtask

    task automatic apply_detent(input bit up);
        bit fast;
        fast = m_prev && (cyc - m_last_cyc) <= FW;
        m_param[m_sel] = model_step(m_param[m_sel], up, fast);
        m_prev = 1'b1; m_last_cyc = cyc;
        stb = 1'b1; click = 1'b1; cw = up;
    endtask

    task automatic detent(input bit up, input int extra);
        repeat (extra) tick();
        apply_detent(up);
        tick();
        stb = 1'b0; click = 1'b0;
        repeat (3) tick();
        chk("detent_params", param_flat, model_flat());
    endtask

    task automatic short_press();
        sw = 1'b0;
        repeat (3) tick();
        sw = 1'b1;
        tick(); tick();
        m_sel = (m_sel + 1) % NP;
        chk("short_press_sel", param_sel, m_sel);
    endtask

    task automatic set_to(input int target);
        int d;
        for (int k = 0; k < 300 && m_param[m_sel] != target; k++) begin
            d = target - m_param[m_sel];
            detent(d > 0, (d >= FS || d <= -FS) ? 0 : 30);
        end
        chk("set_to", param_flat[m_sel*PW +: PW], target);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        tbl.push_back('{1'b1, 0, 'h81, 1'b1});      // first detent after reset is slow
        tbl.push_back('{1'b1, 30, 'h82, 1'b1});
        tbl.push_back('{1'b1, 30, 'h83, 1'b1});
        tbl.push_back('{1'b0, 30, 'h82, 1'b1});
        for (int k = 1; k <= 32; k++) tbl.push_back('{1'b0, 0, 'h82 - 4*k, 1'b1});
        tbl.push_back('{1'b0, 30, 'h01, 1'b1});
        tbl.push_back('{1'b0, 0, 'h00, 1'b1});      // clamped at zero
        tbl.push_back('{1'b0, 0, 'h00, 1'b0});      // no change, no notification
        tbl.push_back('{1'b1, 30, 'h01, 1'b1});
        tbl.push_back('{1'b1, 0, 'h05, 1'b1});

        // Reset release: every parameter is announced, one per cycle.
        upd_ready = 1'b1;
        do_reset();
        for (int i = 0; i < NP; i++) begin
            tick();
            chk("init_valid", upd_valid, 1);
            chk("init_index", upd_index, i);
            chk("init_value", upd_value, 'h80);
        end
        tick();
        chk("init_idle", upd_valid, 0);
        q_rd = notes.size();

        // Detent table on param0.
        foreach (tbl[v]) begin
            detent(tbl[v].up, tbl[v].extra);
            chk("tbl_value", param_flat[PW-1:0], tbl[v].exp_val);
            if (tbl[v].exp_note) begin
                chk("tbl_note_count", notes.size() - q_rd, 1);
                if (notes.size() > q_rd) begin
                    chk("tbl_note_index", notes[q_rd].idx, 0);
                    chk("tbl_note_value", notes[q_rd].val, tbl[v].exp_val);
                end
            end else begin
                chk("tbl_no_note", notes.size() - q_rd, 0);
            end
            q_rd = notes.size();
        end

        // Selection, wrap, and detent coinciding with short-press completion.
        short_press();
        detent(1'b1, 30);
        chk("param1_after_sel", param_flat[2*PW-1:PW], 'h81);
        short_press(); short_press(); short_press();
        chk("sel_wrapped", param_sel, 0);
        sw = 1'b0;
        repeat (3) tick();
        sw = 1'b1;
        apply_detent(1'b1);
        m_sel = (m_sel + 1) % NP;
        tick();
        stb = 1'b0; click = 1'b0;
        repeat (3) tick();
        chk("detent_with_release_params", param_flat, model_flat());
        chk("detent_with_release_sel", param_sel, m_sel);
        q_rd = notes.size();

        // Back-pressure coalescing.
        do_reset();
        drain();
        upd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            detent(1'b1, 30);
            chk("stall_valid", upd_valid, 1);
            chk("stall_index", upd_index, 0);
            chk("stall_value", upd_value, 'h81);
        end
        upd_ready = 1'b1;
        repeat (6) tick();
        chk("coalesce_count", notes.size() - q_rd, 2);
        if (notes.size() >= q_rd + 2) begin
            chk("coalesce_first", notes[q_rd].val, 'h81);
            chk("coalesce_second", notes[q_rd+1].val, 'h85);
        end
        q_rd = notes.size();

        // Reset while a notification is stalled.
        upd_ready = 1'b0;
        detent(1'b0, 30);
        chk("pre_reset_valid", upd_valid, 1);
        do_reset();
        drain();

        // Upper clamp, then long-press restore on param2.
        short_press(); short_press();
        set_to('hFE);
        detent(1'b1, 0);
        chk("upper_clamp", param_flat[3*PW-1:2*PW], 'hFF);
        repeat (4) tick();
        q_rd = notes.size();
        detent(1'b1, 0);
        chk("clamp_no_note", notes.size() - q_rd, 0);
        set_to('hF0);
        q_rd = notes.size();
        sw = 1'b0;
        tick();
        repeat (LP) tick();
        chk("long_press_early", param_flat[3*PW-1:2*PW], 'hF0);
        tick();
        chk("long_press_restore", param_flat[3*PW-1:2*PW], 'h80);
        m_param[2] = 128;
        repeat (4) tick();
        chk("long_press_note_count", notes.size() - q_rd, 1);
        if (notes.size() > q_rd) begin
            chk("long_press_note_index", notes[q_rd].idx, 2);
            chk("long_press_note_value", notes[q_rd].val, 'h80);
        end
        repeat (10) tick();
        sw = 1'b1;
        repeat (3) tick();
        chk("long_press_sel_kept", param_sel, 2);
        chk("long_press_params", param_flat, model_flat());
        chk("long_press_single_note", notes.size() - q_rd, 1);

        // Randomized run with random back-pressure.
        do_reset();
        drain();
        rnd_ready = 1'b1;
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 9) == 0) short_press();
            else detent(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10))
                                                    : int'($urandom_range(20, 30)));
        end
        rnd_ready = 1'b0;
        upd_ready = 1'b1;
        for (int k = 0; k < 50 && upd_valid; k++) tick();
        chk("random_drain_done", upd_valid, 0);
        repeat (2) tick();
        for (int i = 0; i < NP; i++) chk("random_last_notified", last_val[i], m_param[i]);
        chk("random_params", param_flat, model_flat());

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
